// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan driver: FSM and digit
// index enums, cathode patterns and segment codes ({A..G}, A = bit 6).
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        HUND = 2'd0,
        TENS = 2'd1,
        ONES = 2'd2
    } digit_t;

    // Active-low digit enables; bit3 is not wired to a digit and stays high.
    localparam logic [3:0] CATH_HUND = 4'b1011;
    localparam logic [3:0] CATH_TENS = 4'b1101;
    localparam logic [3:0] CATH_ONES = 4'b1110;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1110011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Double-dabble correction applied to each BCD nibble before a shift.
    function automatic logic [3:0] dd_adjust(input logic [3:0] nib);
        return (nib > 4'd4) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational BCD digit to 7-segment encoder; non-decimal codes go blank.
module seg7_encode
    import seg_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Sequential binary-to-BCD converter with a 1-deep latest-wins pending buffer,
// feeding a multiplexed 3-digit 7-segment scanner. Optional: LEADING_ZERO_BLANK_EN.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = 1024,
    parameter int DIV_W    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] value_in,
    input  logic       value_valid,
    output logic       busy,
    output logic [6:0] seg,
    output logic [3:0] cathode
);

    state_t             r_state;
    state_t             w_next;
    logic [7:0]         r_bin;
    logic [11:0]        r_bcd;
    logic [2:0]         r_iter;
    logic [7:0]         r_pend;
    logic               r_pend_vld;
    logic [3:0]         r_hund;
    logic [3:0]         r_tens;
    logic [3:0]         r_ones;
    logic [DIV_W-1:0]   r_presc;
    digit_t             r_idx;

    logic [11:0]        w_adj;
    logic [19:0]        w_shift;
    logic               w_wrap;
    logic [3:0]         w_digit;
    logic [6:0]         w_enc;
    logic               w_blank;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (value_valid) w_next = CONV;
            CONV:    if (r_iter == 3'd7) w_next = COMMIT;
            COMMIT:  w_next = (value_valid || r_pend_vld) ? CONV : IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign busy    = (r_state != IDLE);
    assign w_adj   = {dd_adjust(r_bcd[11:8]), dd_adjust(r_bcd[7:4]), dd_adjust(r_bcd[3:0])};
    assign w_shift = {w_adj, r_bin} << 1;

    // A strobe arriving in COMMIT outranks the buffered value, which is discarded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bin      <= '0;
            r_bcd      <= '0;
            r_iter     <= '0;
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
            r_hund     <= '0;
            r_tens     <= '0;
            r_ones     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (value_valid) begin
                        r_bin  <= value_in;
                        r_bcd  <= '0;
                        r_iter <= '0;
                    end
                end
                CONV: begin
                    r_bcd  <= w_shift[19:8];
                    r_bin  <= w_shift[7:0];
                    r_iter <= r_iter + 3'd1;
                    if (value_valid) begin
                        r_pend     <= value_in;
                        r_pend_vld <= 1'b1;
                    end
                end
                COMMIT: begin
                    r_hund <= r_bcd[11:8];
                    r_tens <= r_bcd[7:4];
                    r_ones <= r_bcd[3:0];
                    r_bcd  <= '0;
                    r_iter <= '0;
                    r_pend_vld <= 1'b0;
                    if (value_valid)     r_bin <= value_in;
                    else if (r_pend_vld) r_bin <= r_pend;
                end
                default: ;
            endcase
        end
    end

    assign w_wrap = (r_presc == DIV_W'(SCAN_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= HUND;
        end else begin
            r_presc <= w_wrap ? '0 : r_presc + 1'b1;
            if (w_wrap) begin
                case (r_idx)
                    HUND:    r_idx <= TENS;
                    TENS:    r_idx <= ONES;
                    default: r_idx <= HUND;
                endcase
            end
        end
    end

    always_comb begin
        w_digit = r_hund;
        cathode = CATH_HUND;
        case (r_idx)
            HUND:    begin w_digit = r_hund; cathode = CATH_HUND; end
            TENS:    begin w_digit = r_tens; cathode = CATH_TENS; end
            ONES:    begin w_digit = r_ones; cathode = CATH_ONES; end
            default: begin w_digit = r_hund; cathode = CATH_HUND; end
        endcase
    end

    always_comb begin
        w_blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        case (r_idx)
            HUND:    w_blank = (r_hund == 4'd0);
            TENS:    w_blank = (r_hund == 4'd0) && (r_tens == 4'd0);
            default: w_blank = 1'b0;
        endcase
`endif
    end

    seg7_encode u_enc (
        .i_bcd (w_digit),
        .o_seg (w_enc)
    );

    assign seg = w_blank ? SEG_BLANK : w_enc;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Testbench for seg_scan_driver: directed scenarios and random strobes checked
// every cycle against a transaction-level timeline model of display and busy.
module tb_seg_scan_driver;

    localparam int SCAN_DIV = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] value_in;
    logic       value_valid;
    logic       busy;
    logic [6:0] seg;
    logic [3:0] cathode;

    int n_checks = 0;
    int n_errors = 0;

    seg_scan_driver #(.SCAN_DIV(SCAN_DIV), .DIV_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .value_in    (value_in),
        .value_valid (value_valid),
        .busy        (busy),
        .seg         (seg),
        .cathode     (cathode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a conversion started at edge S commits at edge S+9.
    int         m_edge = 0;
    int         m_n    = 0;
    bit         m_act  = 0;
    int         m_end  = 0;
    int         m_val  = 0;
    bit         m_pv   = 0;
    int         m_pval = 0;
    int         m_disp = 0;

    function automatic logic [6:0] enc(input int d);
        logic [6:0] tbl [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                 7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1110011};
        return (d >= 0 && d <= 9) ? tbl[d] : 7'b0000000;
    endfunction

    function automatic int cur_idx();
        return (m_n / SCAN_DIV) % 3;
    endfunction

    function automatic logic [3:0] exp_cath();
        case (cur_idx())
            0:       return 4'b1011;
            1:       return 4'b1101;
            default: return 4'b1110;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg();
        int h = m_disp / 100;
        int t = (m_disp / 10) % 10;
        int o = m_disp % 10;
        int idx = cur_idx();
`ifdef LEADING_ZERO_BLANK_EN
        if (idx == 0 && h == 0) return 7'b0000000;
        if (idx == 1 && h == 0 && t == 0) return 7'b0000000;
`endif
        return enc(idx == 0 ? h : (idx == 1 ? t : o));
    endfunction

    task automatic step(input bit rst_v, input bit vv, input logic [7:0] v);
        rst_n = rst_v;
        value_valid = vv;
        value_in = v;
        @(posedge clk);
        m_edge++;
        if (!rst_v) begin
            m_n = 0; m_act = 0; m_pv = 0; m_disp = 0;
        end else begin
            m_n++;
            if (m_act && m_edge == m_end) begin
                m_disp = m_val;
                if (vv) begin
                    m_val = int'(v); m_end = m_edge + 9; m_pv = 0;
                end else if (m_pv) begin
                    m_val = m_pval; m_end = m_edge + 9; m_pv = 0;
                end else begin
                    m_act = 0;
                end
            end else if (!m_act) begin
                if (vv) begin
                    m_act = 1; m_val = int'(v); m_end = m_edge + 9;
                end
            end else if (vv) begin
                m_pv = 1; m_pval = int'(v);
            end
        end
        #1;
        value_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [6:0] rst_seg;
`ifdef LEADING_ZERO_BLANK_EN
        rst_seg = 7'b0000000;
`else
        rst_seg = 7'b1111110;
`endif
        step(0, 0, 8'd0);
        step(0, 0, 8'd0);
        n_checks += 3;
        if (busy !== 1'b0) begin
            n_errors++; $display("FAIL reset busy: got %b exp 0", busy);
        end
        if (cathode !== 4'b1011) begin
            n_errors++; $display("FAIL reset cathode: got %b exp 1011", cathode);
        end
        if (seg !== rst_seg) begin
            n_errors++; $display("FAIL reset seg: got %b exp %b", seg, rst_seg);
        end
    endtask

    task automatic test_single();
        int busy_cnt = 0;
        for (int i = 0; i < 26; i++) begin
            step(1, i == 0, 8'd233);
            if (busy === 1'b1) busy_cnt++;
            n_checks += 3;
            if (busy !== m_act) begin
                n_errors++; $display("FAIL single busy t=%0d: got %b exp %b", i, busy, m_act);
            end
            if (cathode !== exp_cath()) begin
                n_errors++; $display("FAIL single cathode t=%0d: got %b exp %b", i, cathode, exp_cath());
            end
            if (seg !== exp_seg()) begin
                n_errors++; $display("FAIL single seg t=%0d: got %b exp %b", i, seg, exp_seg());
            end
        end
        n_checks++;
        if (busy_cnt != 9) begin
            n_errors++; $display("FAIL single busy_len: got %0d exp 9", busy_cnt);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 32; i++) begin
            logic [7:0] v;
            v = (i == 0) ? 8'd255 : ((i == 3) ? 8'd7 : 8'd42);
            step(1, (i == 0) || (i == 3) || (i == 5), v);
            n_checks += 3;
            if (busy !== m_act) begin
                n_errors++; $display("FAIL b2b busy t=%0d: got %b exp %b", i, busy, m_act);
            end
            if (cathode !== exp_cath()) begin
                n_errors++; $display("FAIL b2b cathode t=%0d: got %b exp %b", i, cathode, exp_cath());
            end
            if (seg !== exp_seg()) begin
                n_errors++; $display("FAIL b2b seg t=%0d: got %b exp %b", i, seg, exp_seg());
            end
        end
    endtask

    task automatic test_commit_strobe();
        for (int i = 0; i < 32; i++) begin
            step(1, (i == 0) || (i == 9), (i == 0) ? 8'd100 : 8'd9);
            n_checks += 3;
            if (busy !== m_act) begin
                n_errors++; $display("FAIL commit busy t=%0d: got %b exp %b", i, busy, m_act);
            end
            if (cathode !== exp_cath()) begin
                n_errors++; $display("FAIL commit cathode t=%0d: got %b exp %b", i, cathode, exp_cath());
            end
            if (seg !== exp_seg()) begin
                n_errors++; $display("FAIL commit seg t=%0d: got %b exp %b", i, seg, exp_seg());
            end
        end
    endtask

    task automatic test_blank_values();
        for (int i = 0; i < 44; i++) begin
            step(1, (i == 0) || (i == 22), (i == 0) ? 8'd5 : 8'd0);
            n_checks += 2;
            if (cathode !== exp_cath()) begin
                n_errors++; $display("FAIL blank cathode t=%0d: got %b exp %b", i, cathode, exp_cath());
            end
            if (seg !== exp_seg()) begin
                n_errors++; $display("FAIL blank seg t=%0d: got %b exp %b", i, seg, exp_seg());
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 28; i++) begin
            step(!(i == 4 || i == 5), (i == 0) || (i == 2), (i == 0) ? 8'd200 : 8'd77);
            n_checks += 3;
            if (busy !== m_act) begin
                n_errors++; $display("FAIL rstmid busy t=%0d: got %b exp %b", i, busy, m_act);
            end
            if (cathode !== exp_cath()) begin
                n_errors++; $display("FAIL rstmid cathode t=%0d: got %b exp %b", i, cathode, exp_cath());
            end
            if (seg !== exp_seg()) begin
                n_errors++; $display("FAIL rstmid seg t=%0d: got %b exp %b", i, seg, exp_seg());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            bit rv;
            bit vv;
            rv = ($urandom_range(0, 299) != 0);
            vv = ($urandom_range(0, 5) == 0);
            step(rv, vv, 8'($urandom_range(0, 255)));
            n_checks += 3;
            if (busy !== m_act) begin
                n_errors++; $display("FAIL random busy t=%0d: got %b exp %b", i, busy, m_act);
            end
            if (cathode !== exp_cath()) begin
                n_errors++; $display("FAIL random cathode t=%0d: got %b exp %b", i, cathode, exp_cath());
            end
            if (seg !== exp_seg()) begin
                n_errors++; $display("FAIL random seg t=%0d: got %b exp %b disp=%0d", i, seg, exp_seg(), m_disp);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        value_valid = 1'b0;
        value_in = 8'd0;
        test_reset();
        test_single();
        test_back_to_back();
        test_commit_strobe();
        test_blank_values();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
